// File: rtl/l1_refill_pkg.sv
// Shared definitions for the L1 miss/refill sequencer.
// Holds default widths and modelled latencies, which the L1/L2 tag units and
// the latency scoreboard reuse. Also holds the controller state enum and the
// helper that picks the fill delay.
package l1_refill_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned SEG_W_DEF      = 5;
  localparam int unsigned LAT_W_DEF      = 10;

  localparam int unsigned L1_DELAY_DEF   = 1;
  localparam int unsigned L2_DELAY_DEF   = 20;
  localparam int unsigned DRAM_DELAY_DEF = 400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROBE,
    ST_WAIT,
    ST_FILL,
    ST_DONE
  } state_t;

  // Fill latency of an L1 miss: an L2 hit is served by L2, otherwise by DRAM.
  function automatic int unsigned fill_delay(input logic l2_hit,
                                             input int unsigned l2_delay,
                                             input int unsigned dram_delay);
    return l2_hit ? l2_delay : dram_delay;
  endfunction

endpackage

// File: rtl/l1_refill_ctrl_if.sv
// Bus bundle around the refill controller.
// Groups three things: the coalescer request handshake, the tag-unit
// probe/write signals and the completion handshake.
//   master : the refill controller (drives req_ready, probe_*, tag_*, done_*)
//   slave  : the environment (coalescer, tag unit, completion consumer)
interface l1_refill_ctrl_if
  import l1_refill_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned SEG_W  = SEG_W_DEF,
  parameter int unsigned LAT_W  = LAT_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [SEG_W-1:0]  req_seg;

  logic [ADDR_W-1:0] probe_addr;
  logic [SEG_W-1:0]  probe_seg;
  logic              l1_hit;
  logic              l2_hit;
  logic              tag_stall;
  logic              tag_write;
  logic [ADDR_W-1:0] tag_write_addr;

  logic              done_valid;
  logic              done_ready;
  logic [SEG_W-1:0]  done_seg;
  logic [LAT_W-1:0]  done_latency;

  modport master (
    input  req_valid, req_addr, req_seg, l1_hit, l2_hit, done_ready,
    output req_ready, probe_addr, probe_seg, tag_stall, tag_write,
           tag_write_addr, done_valid, done_seg, done_latency
  );

  modport slave (
    output req_valid, req_addr, req_seg, l1_hit, l2_hit, done_ready,
    input  req_ready, probe_addr, probe_seg, tag_stall, tag_write,
           tag_write_addr, done_valid, done_seg, done_latency
  );

endinterface

// File: rtl/l1_refill_delay_cnt.sv
// Loadable down-counter that models the L2/DRAM fill delay.
//   clk, reset  : clock, synchronous active-high reset
//   en_i        : global enable; when low, the counter holds
//   load_i      : load load_val_i (wins over dec_i)
//   dec_i       : decrement by one, saturating at zero
//   load_val_i  : value to load
//   zero_o      : counter is zero
module l1_refill_delay_cnt #(
  parameter int unsigned LAT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  // Next count: load, then saturating decrement, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - LAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/l1_refill_ctrl.sv
// Single-outstanding miss/refill sequencer for the L1 tag unit.
// It accepts one coalesced segment request and probes the L1 and L2 tags in
// one cycle. On an L1 miss it counts down the L2 or DRAM fill delay, then
// issues one tag write to install the line. Finally it reports the segment
// together with its modelled latency.
//   clk, reset  : clock, synchronous active-high reset
//   pipe_stall  : global stall; freezes state, counter and latched data
//   bus         : request / tag-unit / completion bundle (master side)
module l1_refill_ctrl
  import l1_refill_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned SEG_W      = SEG_W_DEF,
  parameter int unsigned LAT_W      = LAT_W_DEF,
  parameter int unsigned L1_DELAY   = L1_DELAY_DEF,
  parameter int unsigned L2_DELAY   = L2_DELAY_DEF,
  parameter int unsigned DRAM_DELAY = DRAM_DELAY_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_stall,
  l1_refill_ctrl_if.master bus
);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SEG_W-1:0]  seg_q;
  logic [LAT_W-1:0]  lat_q;
  logic              req_ready_q;
  logic              tag_stall_q;
  logic              tag_write_q;
  logic              done_valid_q;

  logic              run_c;
  logic              cnt_load_c;
  logic              cnt_zero_c;
  logic [LAT_W-1:0]  fill_lat_c;

  assign run_c      = ~pipe_stall;
  assign fill_lat_c = LAT_W'(fill_delay(bus.l2_hit, L2_DELAY, DRAM_DELAY));
  // The counter is loaded with delay-1 so that WAIT spans exactly `delay` cycles.
  assign cnt_load_c = (state_q == ST_PROBE) && !bus.l1_hit;

  l1_refill_delay_cnt #(
    .LAT_W (LAT_W)
  ) u_delay_cnt (
    .clk        (clk),
    .reset      (reset),
    .en_i       (run_c),
    .load_i     (cnt_load_c),
    .dec_i      (state_q == ST_WAIT),
    .load_val_i (fill_lat_c - LAT_W'(1)),
    .zero_o     (cnt_zero_c)
  );

  // Sequencer; output flags are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      seg_q        <= '0;
      lat_q        <= '0;
      req_ready_q  <= 1'b1;
      tag_stall_q  <= 1'b1;
      tag_write_q  <= 1'b0;
      done_valid_q <= 1'b0;
    end else if (run_c) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            state_q     <= ST_PROBE;
            addr_q      <= bus.req_addr;
            seg_q       <= bus.req_seg;
            req_ready_q <= 1'b0;
            tag_stall_q <= 1'b0;
          end
        end
        ST_PROBE: begin
          // A repeated-address probe reports a miss; that is refilled like any miss.
          tag_stall_q <= 1'b1;
          if (bus.l1_hit) begin
            state_q      <= ST_DONE;
            lat_q        <= LAT_W'(L1_DELAY);
            done_valid_q <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
            lat_q   <= fill_lat_c;
          end
        end
        ST_WAIT: begin
          if (cnt_zero_c) begin
            state_q     <= ST_FILL;
            tag_stall_q <= 1'b0;
            tag_write_q <= 1'b1;
          end
        end
        ST_FILL: begin
          state_q      <= ST_DONE;
          tag_stall_q  <= 1'b1;
          tag_write_q  <= 1'b0;
          done_valid_q <= 1'b1;
        end
        ST_DONE: begin
          if (bus.done_ready) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            seg_q        <= '0;
            req_ready_q  <= 1'b1;
            done_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // A stall must block the tag unit and the request port in the very cycle it is raised.
  assign bus.req_ready      = req_ready_q & run_c;
  assign bus.tag_stall      = tag_stall_q | pipe_stall;
  assign bus.tag_write      = tag_write_q & run_c;
  assign bus.tag_write_addr = addr_q;
  assign bus.probe_addr     = addr_q;
  assign bus.probe_seg      = seg_q;
  assign bus.done_valid     = done_valid_q;
  assign bus.done_seg       = seg_q;
  assign bus.done_latency   = lat_q;

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Testbench for l1_refill_ctrl: directed vector table, a backpressure
// sequence, then random traffic checked against a timeline model.
module tb_l1_refill_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned LW = 10;
  localparam int L2D = 20;
  localparam int DRD = 400;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pipe_stall = 1'b0;

  l1_refill_ctrl_if #(.ADDR_W(AW), .SEG_W(SW), .LAT_W(LW)) bus ();

  l1_refill_ctrl #(
    .ADDR_W(AW), .SEG_W(SW), .LAT_W(LW),
    .L1_DELAY(1), .L2_DELAY(L2D), .DRAM_DELAY(DRD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_stall (pipe_stall),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  seg;
    bit          l1;
    bit          l2;
    int          stall_at;
    int          stall_len;
    int          rst_at;
    int          exp_wcyc;
    int          exp_dcyc;
    logic [9:0]  exp_lat;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs[NVEC];

  // One request accepted at edge 0, done_ready held high; cycle numbers follow the timing rules.
  task automatic run_vec(input vec_t v, input int idx);
    int wcyc, dcyc, wcnt;
    logic [31:0] waddr;
    logic [4:0]  dseg;
    logic [9:0]  dlat;
    bit stop;
    wcyc = -1; dcyc = -1; wcnt = 0; waddr = '0; dseg = '0; dlat = '0; stop = 0;
    bus.req_valid = 1'b1; bus.req_addr = v.addr; bus.req_seg = v.seg;
    bus.l1_hit = v.l1; bus.l2_hit = v.l2; bus.done_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr = $urandom;
    bus.req_seg = 5'($urandom);
    for (int cyc = 1; cyc <= 460 && !stop; cyc++) begin
      pipe_stall = (cyc >= v.stall_at) && (cyc < v.stall_at + v.stall_len);
      reset = (cyc == v.rst_at);
      @(negedge clk);
      if (pipe_stall) begin
        chk($sformatf("v%0d_stall_tag_write", idx), 32'(bus.tag_write), 32'd0);
        chk($sformatf("v%0d_stall_tag_stall", idx), 32'(bus.tag_stall), 32'd1);
        chk($sformatf("v%0d_stall_req_ready", idx), 32'(bus.req_ready), 32'd0);
      end
      if (v.rst_at > 0 && cyc == v.rst_at + 1) begin
        chk($sformatf("v%0d_rst_req_ready", idx), 32'(bus.req_ready), 32'd1);
        chk($sformatf("v%0d_rst_tag_stall", idx), 32'(bus.tag_stall), 32'd1);
        chk($sformatf("v%0d_rst_tag_write", idx), 32'(bus.tag_write), 32'd0);
        chk($sformatf("v%0d_rst_done_valid", idx), 32'(bus.done_valid), 32'd0);
        chk($sformatf("v%0d_rst_latency", idx), 32'(bus.done_latency), 32'd0);
        chk($sformatf("v%0d_rst_probe_addr", idx), bus.probe_addr, 32'd0);
      end
      if (bus.tag_write === 1'b1) begin
        wcnt++;
        if (wcyc < 0) begin
          wcyc = cyc;
          waddr = bus.tag_write_addr;
        end
      end
      if (bus.done_valid === 1'b1) begin
        dcyc = cyc; dseg = bus.done_seg; dlat = bus.done_latency; stop = 1;
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    pipe_stall = 1'b0;
    bus.done_ready = 1'b0;
    chk($sformatf("v%0d_write_cycle", idx), 32'(wcyc), 32'(v.exp_wcyc));
    chk($sformatf("v%0d_write_count", idx), 32'(wcnt), (v.exp_wcyc >= 0) ? 32'd1 : 32'd0);
    chk($sformatf("v%0d_done_cycle", idx), 32'(dcyc), 32'(v.exp_dcyc));
    if (v.exp_wcyc >= 0) chk($sformatf("v%0d_write_addr", idx), waddr, v.addr);
    if (v.exp_dcyc >= 0) begin
      chk($sformatf("v%0d_done_seg", idx), 32'(dseg), 32'(v.seg));
      chk($sformatf("v%0d_done_latency", idx), 32'(dlat), 32'(v.exp_lat));
    end
  endtask

  // Timeline model: one entry per unstalled cycle left before DONE (0 = waiting, 1 = fill).
  bit          m_busy;
  bit          m_probe;
  bit          m_plan[$];
  logic [31:0] m_addr;
  logic [4:0]  m_seg;
  logic [9:0]  m_lat;

  task automatic model_check();
    bit e_rr, e_ts, e_tw, e_dv;
    if (!m_busy) begin
      e_rr = !pipe_stall; e_ts = 1; e_tw = 0; e_dv = 0;
    end else if (m_probe) begin
      e_rr = 0; e_ts = pipe_stall; e_tw = 0; e_dv = 0;
    end else if (m_plan.size() != 0) begin
      e_rr = 0; e_dv = 0;
      if (m_plan[0]) begin
        e_ts = pipe_stall; e_tw = !pipe_stall;
      end else begin
        e_ts = 1; e_tw = 0;
      end
    end else begin
      e_rr = 0; e_ts = 1; e_tw = 0; e_dv = 1;
    end
    chk("rnd_req_ready", 32'(bus.req_ready), 32'(e_rr));
    chk("rnd_tag_stall", 32'(bus.tag_stall), 32'(e_ts));
    chk("rnd_tag_write", 32'(bus.tag_write), 32'(e_tw));
    chk("rnd_done_valid", 32'(bus.done_valid), 32'(e_dv));
    chk("rnd_probe_addr", bus.probe_addr, m_addr);
    chk("rnd_probe_seg", 32'(bus.probe_seg), 32'(m_seg));
    if (e_tw) chk("rnd_write_addr", bus.tag_write_addr, m_addr);
    if (e_dv) begin
      chk("rnd_done_seg", 32'(bus.done_seg), 32'(m_seg));
      chk("rnd_done_latency", 32'(bus.done_latency), 32'(m_lat));
    end
  endtask

  task automatic model_step();
    int d;
    if (reset) begin
      m_busy = 0; m_probe = 0; m_plan.delete(); m_addr = '0; m_seg = '0;
    end else if (!pipe_stall) begin
      if (!m_busy) begin
        if (bus.req_valid) begin
          m_busy = 1; m_probe = 1; m_addr = bus.req_addr; m_seg = bus.req_seg;
        end
      end else if (m_probe) begin
        m_probe = 0;
        if (bus.l1_hit) begin
          m_lat = 10'd1;
        end else begin
          d = bus.l2_hit ? L2D : DRD;
          m_lat = 10'(d);
          repeat (d) m_plan.push_back(1'b0);
          m_plan.push_back(1'b1);
        end
      end else if (m_plan.size() != 0) begin
        void'(m_plan.pop_front());
      end else if (bus.done_ready) begin
        m_busy = 0; m_addr = '0; m_seg = '0;
      end
    end
  endtask

  initial begin
    bit checking;
    //           addr          seg    l1 l2 stall len rst  wcyc  dcyc  lat
    vecs[0] = '{32'h0000_1040, 5'd3,  1, 0, -1,   0,  -1,  -1,   2,    10'd1};
    vecs[1] = '{32'h0000_1040, 5'd3,  0, 1, -1,   0,  -1,  22,   23,   10'd20};
    vecs[2] = '{32'h0000_1040, 5'd3,  0, 0, -1,   0,  -1,  402,  403,  10'd400};
    vecs[3] = '{32'hFFFF_FFC0, 5'd31, 1, 1, -1,   0,  -1,  -1,   2,    10'd1};
    vecs[4] = '{32'h0000_1040, 5'd3,  0, 1, 5,    3,  -1,  25,   26,   10'd20};
    vecs[5] = '{32'h0000_2080, 5'd9,  0, 1, 22,   2,  -1,  24,   25,   10'd20};
    vecs[6] = '{32'h0000_0100, 5'd1,  1, 0, 1,    1,  -1,  -1,   3,    10'd1};
    vecs[7] = '{32'h0000_2000, 5'd9,  0, 0, 10,   1,  10,  -1,   -1,   10'd0};

    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_seg = '0;
    bus.l1_hit = 1'b0; bus.l2_hit = 1'b0; bus.done_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_tag_stall", 32'(bus.tag_stall), 32'd1);
    chk("reset_tag_write", 32'(bus.tag_write), 32'd0);
    chk("reset_done_valid", 32'(bus.done_valid), 32'd0);
    chk("reset_done_latency", 32'(bus.done_latency), 32'd0);
    chk("reset_probe_addr", bus.probe_addr, 32'd0);
    chk("reset_probe_seg", 32'(bus.probe_seg), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Backpressure: completion held for 5 cycles, then a request right after the handshake.
    bus.req_valid = 1'b1; bus.req_addr = 32'h0000_3000; bus.req_seg = 5'd12;
    bus.l1_hit = 1'b1; bus.l2_hit = 1'b0; bus.done_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_done_valid", 32'(bus.done_valid), 32'd1);
      chk("bp_done_seg", 32'(bus.done_seg), 32'd12);
      chk("bp_done_latency", 32'(bus.done_latency), 32'd1);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.done_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_valid_hs", 32'(bus.done_valid), 32'd1);
    @(posedge clk); #1;
    bus.done_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 32'h0000_4000; bus.req_seg = 5'd2;
    @(negedge clk);
    chk("bp_req_ready_after", 32'(bus.req_ready), 32'd1);
    chk("bp_done_valid_after", 32'(bus.done_valid), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_new_probe_addr", bus.probe_addr, 32'h0000_4000);
    chk("bp_new_tag_stall", 32'(bus.tag_stall), 32'd0);
    chk("bp_new_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    bus.done_ready = 1'b1;
    @(negedge clk);
    chk("bp_new_done_valid", 32'(bus.done_valid), 32'd1);
    chk("bp_new_done_seg", 32'(bus.done_seg), 32'd2);
    @(posedge clk); #1;
    bus.done_ready = 1'b0;

    // Random traffic against the timeline model.
    checking = 0;
    for (int c = 0; c < 4000; c++) begin
      reset = (c < 2) || ($urandom_range(0, 299) == 0);
      pipe_stall = ($urandom_range(0, 7) == 0);
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_addr = $urandom;
      bus.req_seg = 5'($urandom);
      bus.l1_hit = ($urandom_range(0, 2) == 0);
      bus.l2_hit = ($urandom_range(0, 5) != 0);
      bus.done_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (checking) model_check();
      model_step();
      if (reset) checking = 1;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
